// File: rtl/spi_cmd_buf_pkg.sv
// Shared sizing helpers for the SPI command arbitration buffer: channel-id width,
// rd_data field layout and drop counter width.
package spi_cmd_buf_pkg;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // A single channel still gets a 1-bit id field so rd_data keeps a fixed layout.
    function automatic int ch_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    function automatic int rd_cmd_lsb();
        return 0;
    endfunction

    function automatic int rd_ch_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int rd_data_w(input int ch_num, input int data_w);
        return ch_w(ch_num) + data_w;
    endfunction

endpackage

// File: rtl/spi_cmd_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and full/empty flags.
// A write into a full FIFO is taken only when a read frees a slot on the same edge.
module spi_cmd_sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_cmd_arb_buffer.sv
// Per-channel command holding registers, round-robin arbitration into a shared FIFO.
// Optional drop statistics are built when SPI_CMD_BUF_DROP_CNT_EN is defined.
module spi_cmd_arb_buffer
    import spi_cmd_buf_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 64
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic [CH_NUM-1:0]                  cmd_wr_en,
    input  logic [CH_NUM*DATA_W-1:0]           cmd_wr_data,
    output logic [CH_NUM-1:0]                  cmd_hold_busy,
    input  logic                               rd_en,
    output logic [rd_data_w(CH_NUM, DATA_W)-1:0] rd_data,
    output logic                               fifo_empty,
    output logic                               fifo_full,
    output logic [$clog2(DEPTH):0]             fifo_count,
    output logic [DROP_CNT_W-1:0]              drop_cnt,
    output logic                               ovf_flag
);

    localparam int CH_W    = ch_w(CH_NUM);
    localparam int ENTRY_W = rd_data_w(CH_NUM, DATA_W);

    logic [CH_NUM-1:0] hold_valid;
    logic [DATA_W-1:0] hold_data [CH_NUM];
    logic [CH_W-1:0]   rr_ptr;
    logic              can_grant;
    logic              grant_any;
    logic [CH_W-1:0]   grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic [CH_NUM-1:0] grant_vec;
    logic [CH_NUM-1:0] accept_vec;
    int                best_d;
    int                d;

    // Handshake: a holding register is a valid source; the FIFO is ready when not
    // full or when rd_en frees a slot this cycle. A transfer happens on valid && ready.
    assign can_grant     = !fifo_full || rd_en;
    assign cmd_hold_busy = hold_valid;

    // Winner is the valid channel at the smallest distance above rr_ptr (mod CH_NUM).
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        best_d     = CH_NUM;
        d          = 0;
        for (int c = 0; c < CH_NUM; c++) begin
            d = c - int'(rr_ptr);
            if (d < 0) begin
                d = d + CH_NUM;
            end
            if (can_grant && hold_valid[c] && (d < best_d)) begin
                best_d     = d;
                grant_any  = 1'b1;
                grant_idx  = CH_W'(c);
                grant_data = hold_data[c];
            end
        end
    end

    // A full holding register can still take a strobe when it is drained on the same edge.
    always_comb begin
        grant_vec  = '0;
        accept_vec = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            grant_vec[c]  = grant_any && (grant_idx == CH_W'(c));
            accept_vec[c] = cmd_wr_en[c] && (!hold_valid[c] || grant_vec[c]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (accept_vec[c]) begin
                    hold_valid[c] <= 1'b1;
                end else if (grant_vec[c]) begin
                    hold_valid[c] <= 1'b0;
                end
            end
            if (grant_any) begin
                if (int'(grant_idx) == CH_NUM - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        for (int c = 0; c < CH_NUM; c++) begin
            if (accept_vec[c]) begin
                hold_data[c] <= cmd_wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    spi_cmd_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (grant_any),
        .wr_data ({grant_idx, grant_data}),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef SPI_CMD_BUF_DROP_CNT_EN
    logic [CH_NUM-1:0]   drop_vec;
    logic [DROP_CNT_W:0] drop_sum;

    always_comb begin
        drop_vec = '0;
        drop_sum = {1'b0, drop_cnt};
        for (int c = 0; c < CH_NUM; c++) begin
            drop_vec[c] = cmd_wr_en[c] && hold_valid[c] && !grant_vec[c];
            drop_sum    = drop_sum + (DROP_CNT_W+1)'(drop_vec[c]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            drop_cnt <= '0;
            ovf_flag <= 1'b0;
        end else begin
            drop_cnt <= drop_sum[DROP_CNT_W] ? DROP_CNT_MAX : drop_sum[DROP_CNT_W-1:0];
            if (|drop_vec) begin
                ovf_flag <= 1'b1;
            end
        end
    end
`else
    assign drop_cnt = '0;
    assign ovf_flag = 1'b0;
`endif

endmodule
